// File: rtl/seg_scan_if.sv
// Bus bundle between a display-data source and the seg_scan_ctrl scanner.
// The bright input exists only when SEG_SCAN_DIM_EN is defined.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     blank_mask;
  logic                  lz_en;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]            bright;
`endif
  logic [3:0]            code_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  frame_done;

`ifdef SEG_SCAN_DIM_EN
  modport master (
    output enable, load, data_in, blank_mask, lz_en, bright,
    input  code_out, digit_sel, frame_done
  );
  modport slave (
    input  enable, load, data_in, blank_mask, lz_en, bright,
    output code_out, digit_sel, frame_done
  );
`else
  modport master (
    output enable, load, data_in, blank_mask, lz_en,
    input  code_out, digit_sel, frame_done
  );
  modport slave (
    input  enable, load, data_in, blank_mask, lz_en,
    output code_out, digit_sel, frame_done
  );
`endif
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with double-buffered frames.
// Optional SEG_SCAN_DIM_EN adds a 3-bit bright input that trims each digit's on-time.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned GAP    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int unsigned CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW   = 4 * DIGITS;

  typedef enum logic [1:0] {ST_OFF, ST_GAP, ST_DRIVE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     shadow_q, shadow_d;
  logic [DW-1:0]     active_q, active_d;
  logic              pending_q, pending_d;
  logic [3:0]        code_q, code_d;
  logic [DIGITS-1:0] sel_q, sel_d;
  logic              done_q, done_d;

  logic              frame_start;
  logic [DIGITS-1:0] lz_zero;
  logic              tail;
  logic              dark;
  logic              lit;
`ifdef SEG_SCAN_DIM_EN
  logic [31:0]       on_lim;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '1;
      active_q  <= '1;
      pending_q <= 1'b0;
      code_q    <= 4'hF;
      sel_q     <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
    end
  end

  // Next state, buffering, and outputs decoded from the next-state values so they line up with the state register.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pending_d   = pending_q;
    frame_start = 1'b0;
    code_d      = 4'hF;
    sel_d       = '1;
    done_d      = 1'b0;
    lz_zero     = '0;
    tail        = 1'b1;
    dark        = 1'b0;
    lit         = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    on_lim      = '0;
`endif

    if (!bus.enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d     = ST_GAP;
          idx_d       = '0;
          cnt_d       = '0;
          frame_start = 1'b1;
        end
        ST_GAP: begin
          if (cnt_q == CW'(GAP - 1)) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt_q == CW'(DIV - 1)) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
              idx_d       = '0;
              frame_start = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // A load coinciding with a frame start bypasses the shadow so it shows in this frame.
    if (bus.load) begin
      shadow_d  = bus.data_in;
      pending_d = 1'b1;
    end
    if (frame_start) begin
      if (bus.load) begin
        active_d  = bus.data_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail       = tail & (active_d[4*i +: 4] == 4'h0);
      lz_zero[i] = tail;
    end

    dark = bus.blank_mask[idx_d] | (bus.lz_en & (idx_d != '0) & lz_zero[idx_d]);
    lit  = (state_d == ST_DRIVE) & ~dark;
`ifdef SEG_SCAN_DIM_EN
    on_lim = ((32'(bus.bright) + 32'd1) * 32'(DIV)) >> 3;
    lit    = lit & (32'(cnt_d) < on_lim);
`endif
    if (lit) begin
      sel_d  = ~(DIGITS'(1) << idx_d);
      code_d = active_d[{idx_d, 2'b00} +: 4];
    end
    done_d = (state_d == ST_DRIVE) && (idx_d == IW'(DIGITS - 1)) && (cnt_d == CW'(DIV - 1));
  end

  assign bus.code_out   = code_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=4, DIV=4, GAP=2): frame-position reference
// model feeding a per-cycle scoreboard queue, plus directed checks per scenario.
module tb_seg_scan_ctrl;
  localparam int unsigned D  = 4;
  localparam int unsigned V  = 4;
  localparam int unsigned G  = 2;
  localparam int unsigned FR = D * (G + V);

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] code;
    logic       done;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_ctrl #(.DIGITS(D), .DIV(V), .GAP(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic        m_run;
  int          m_pos;
  logic [15:0] m_shadow, m_active;
  logic        m_pend;
  out_t        exp_q[$];

  always @(posedge clk) begin : model
    logic fs, tz, dk;
    int slot, off;
    out_t e;
    if (!rst_n) begin
      m_run = 1'b0; m_pos = 0; m_shadow = 16'hFFFF; m_active = 16'hFFFF; m_pend = 1'b0;
    end else begin
      fs = 1'b0;
      if (!bus.enable) m_run = 1'b0;
      else if (!m_run) begin m_run = 1'b1; m_pos = 0; fs = 1'b1; end
      else if (m_pos == FR - 1) begin m_pos = 0; fs = 1'b1; end
      else m_pos++;
      if (fs && bus.load) begin
        m_active = bus.data_in; m_shadow = bus.data_in; m_pend = 1'b0;
      end else begin
        if (fs && m_pend) begin m_active = m_shadow; m_pend = 1'b0; end
        if (bus.load) begin m_shadow = bus.data_in; m_pend = 1'b1; end
      end
    end
    e.sel = 4'hF; e.code = 4'hF; e.done = 1'b0;
    if (rst_n && m_run) begin
      slot = m_pos / (G + V);
      off  = m_pos % (G + V);
      if (off >= G) begin
        tz = 1'b1;
        for (int j = slot; j < D; j++) if (m_active[j*4 +: 4] != 4'h0) tz = 1'b0;
        dk = bus.blank_mask[slot] || (bus.lz_en && slot != 0 && tz);
`ifdef SEG_SCAN_DIM_EN
        if ((off - G) >= ((int'(bus.bright) + 1) * V) / 8) dk = 1'b1;
`endif
        if (!dk) begin
          e.sel  = ~(4'(1) << slot);
          e.code = m_active[slot*4 +: 4];
        end
        e.done = (slot == D - 1) && (off == G + V - 1);
      end
    end
    exp_q.push_back(e);
  end

  // Per-window observation statistics
  out_t       obs, cur, first_obs, first_exp;
  int         sb_err, done_cnt, last_done, cyc;
  int         low_cnt[D];
  logic [3:0] code_seen[D];
  logic       saw_a;

  task automatic clear_stats();
    sb_err = 0; done_cnt = 0; last_done = 0; cyc = 0; saw_a = 1'b0;
    for (int d = 0; d < D; d++) begin low_cnt[d] = 0; code_seen[d] = 4'hF; end
  endtask

  // Advance one clock, pop the expected output and accumulate scoreboard/observation stats.
  task automatic step();
    @(negedge clk);
    obs = {bus.digit_sel, bus.code_out, bus.frame_done};
    cyc++;
    if (exp_q.size() == 0) begin
      if (sb_err == 0) begin first_obs = obs; first_exp = 'x; end
      sb_err++;
    end else begin
      cur = exp_q.pop_front();
      if (obs !== cur) begin
        if (sb_err == 0) begin first_obs = obs; first_exp = cur; end
        sb_err++;
      end
    end
    if (obs.done) begin done_cnt++; last_done = cyc; end
    for (int d = 0; d < D; d++)
      if (!obs.sel[d]) begin low_cnt[d]++; code_seen[d] = obs.code; end
    if (obs.sel != 4'hF && obs.code == 4'hA) saw_a = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      if (obs.done) ok = 1'b1;
    end
  endtask

  task automatic wait_sel(input logic [3:0] s, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      step();
      if (obs.sel == s) ok = 1'b1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1; bus.data_in = v;
    step();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    clear_stats();
    rst_n = 1'b0; bus.enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (obs !== {4'hF, 4'hF, 1'b0}) begin
        n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, {4'hF, 4'hF, 1'b0});
      end
    end
    rst_n = 1'b1;
    step(); step();
    n_cmp++;
    if (obs.sel !== 4'hF) begin n_fail++; $display("FAIL reset_gap_sel: got %b want 1111", obs.sel); end
    step();
    n_cmp++;
    if ({obs.sel, obs.code} !== {4'b1110, 4'hF}) begin
      n_fail++; $display("FAIL first_drive: got sel=%b code=%h want sel=1110 code=f", obs.sel, obs.code);
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL reset_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask

  task automatic test_load_frame();
    bit ok;
    logic [3:0] want [D] = '{4'h4, 4'h3, 4'h2, 4'h1};
    run(8);
    do_load(16'h1234);
    clear_stats();
    sync_frame(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL load_sync: got timeout want frame_done"); end
    n_cmp++;
    if (code_seen[3] !== 4'hF) begin n_fail++; $display("FAIL load_torn: got %h want f", code_seen[3]); end
    clear_stats();
    run(FR);
    for (int d = 0; d < D; d++) begin
      n_cmp++;
      if ({low_cnt[d], code_seen[d]} !== {32'(V), want[d]}) begin
        n_fail++; $display("FAIL load_digit%0d: got low=%0d code=%h want low=%0d code=%h", d, low_cnt[d], code_seen[d], V, want[d]);
      end
    end
    n_cmp++;
    if ({done_cnt, last_done} !== {32'd1, 32'(FR)}) begin
      n_fail++; $display("FAIL frame_done_period: got cnt=%0d at=%0d want cnt=1 at=%0d", done_cnt, last_done, FR);
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL load_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask

  task automatic test_lz();
    bit ok;
    run(3);
    do_load(16'h0070);
    sync_frame(ok);
    bus.lz_en = 1'b1;
    clear_stats();
    run(FR);
    n_cmp++;
    if ({low_cnt[3], low_cnt[2], low_cnt[1], low_cnt[0]} !== {32'd0, 32'd0, 32'(V), 32'(V)}) begin
      n_fail++; $display("FAIL lz_on_lit: got %0d %0d %0d %0d want 0 0 %0d %0d", low_cnt[3], low_cnt[2], low_cnt[1], low_cnt[0], V, V);
    end
    n_cmp++;
    if ({code_seen[1], code_seen[0]} !== 8'h70) begin
      n_fail++; $display("FAIL lz_on_codes: got %h%h want 70", code_seen[1], code_seen[0]);
    end
    bus.lz_en = 1'b0;
    clear_stats();
    run(FR);
    n_cmp++;
    if ({low_cnt[3], code_seen[3], code_seen[2]} !== {32'(V), 4'h0, 4'h0}) begin
      n_fail++; $display("FAIL lz_off: got low3=%0d c3=%h c2=%h want low3=%0d c3=0 c2=0", low_cnt[3], code_seen[3], code_seen[2], V);
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL lz_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask

  task automatic test_blank_mask();
    bus.blank_mask = 4'b0100;
    clear_stats();
    run(FR);
    bus.blank_mask = 4'b0000;
    n_cmp++;
    if ({low_cnt[2], low_cnt[3]} !== {32'd0, 32'(V)}) begin
      n_fail++; $display("FAIL blank_mask: got low2=%0d low3=%0d want low2=0 low3=%0d", low_cnt[2], low_cnt[3], V);
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL blank_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [3:0] want [D] = '{4'h6, 4'h7, 4'h8, 4'h9};
    run(2);
    do_load(16'hAAAA);
    step();
    do_load(16'h5555);
    clear_stats();
    sync_frame(ok);
    run(FR);
    n_cmp++;
    if (saw_a !== 1'b0) begin n_fail++; $display("FAIL b2b_first_lost: got A displayed want never"); end
    n_cmp++;
    if ({code_seen[3], code_seen[2], code_seen[1], code_seen[0]} !== 16'h5555) begin
      n_fail++; $display("FAIL b2b_last_wins: got %h%h%h%h want 5555", code_seen[3], code_seen[2], code_seen[1], code_seen[0]);
    end
    n_cmp++;
    if (obs.done !== 1'b1) begin n_fail++; $display("FAIL b2b_at_boundary: got done=%b want 1", obs.done); end
    clear_stats();
    do_load(16'h9876);
    run(FR - 1);
    for (int d = 0; d < D; d++) begin
      n_cmp++;
      if (code_seen[d] !== want[d]) begin
        n_fail++; $display("FAIL same_frame_load%0d: got %h want %h", d, code_seen[d], want[d]);
      end
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL b2b_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask

  task automatic test_disable();
    bit ok1, ok2;
    clear_stats();
    wait_sel(4'b1110, ok1);
    do_load(16'h4321);
    wait_sel(4'b1011, ok2);
    n_cmp++;
    if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL dis_wait: got %b want 11", {ok1, ok2}); end
    bus.enable = 1'b0;
    step();
    n_cmp++;
    if (obs !== {4'hF, 4'hF, 1'b0}) begin n_fail++; $display("FAIL dis_off: got %h want %h", obs, {4'hF, 4'hF, 1'b0}); end
    run(3);
    bus.enable = 1'b1;
    step(); step();
    n_cmp++;
    if (obs.sel !== 4'hF) begin n_fail++; $display("FAIL reen_gap: got %b want 1111", obs.sel); end
    step();
    n_cmp++;
    if ({obs.sel, obs.code} !== {4'b1110, 4'h1}) begin
      n_fail++; $display("FAIL reen_digit0: got sel=%b code=%h want sel=1110 code=1", obs.sel, obs.code);
    end
    run(FR - G - 1);
    n_cmp++;
    if ({code_seen[3], code_seen[2], code_seen[1]} !== 12'h432) begin
      n_fail++; $display("FAIL reen_frame: got %h%h%h want 432", code_seen[3], code_seen[2], code_seen[1]);
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL dis_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask

`ifdef SEG_SCAN_DIM_EN
  task automatic test_dim();
    bus.bright = 3'd1;
    clear_stats();
    run(FR);
    for (int d = 0; d < D; d++) begin
      n_cmp++;
      if (low_cnt[d] !== 1) begin n_fail++; $display("FAIL dim1_digit%0d: got %0d want 1", d, low_cnt[d]); end
    end
    bus.bright = 3'd7;
    clear_stats();
    run(FR);
    for (int d = 0; d < D; d++) begin
      n_cmp++;
      if (low_cnt[d] !== int'(V)) begin n_fail++; $display("FAIL dim7_digit%0d: got %0d want %0d", d, low_cnt[d], V); end
    end
    n_cmp++;
    if (sb_err !== 0) begin n_fail++; $display("FAIL dim_sb: %0d errs first got %h want %h", sb_err, first_obs, first_exp); end
  endtask
`endif

  initial begin
    bus.enable = 1'b1; bus.load = 1'b0; bus.data_in = '0;
    bus.blank_mask = '0; bus.lz_en = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    bus.bright = 3'd7;
`endif
    test_reset();
    test_load_frame();
    test_lz();
    test_blank_mask();
    test_back_to_back();
    test_disable();
`ifdef SEG_SCAN_DIM_EN
    test_dim();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
